// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the multi-cycle ALU slice.
//   OP_W        : opcode field width
//   alu_op_e    : opcode encoding (12..15 are illegal; 11 is illegal when the
//                 multiplier is not built)
//   alu_state_e : IDLE / BUSY / DONE handshake FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_XOR = 4'd3,
        OP_INC = 4'd4,
        OP_DEC = 4'd5,
        OP_NOT = 4'd6,
        OP_OR  = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_SAR = 4'd10,
        OP_MUL = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage : alu_pkg

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned shift-add multiplier: one partial-product step per clock,
// WIDTH steps per multiply. done pulses for one cycle the edge after the last
// step; product/hi_nz then hold until the next start.
//   clk, rst_n : clock, async active-low reset (clears all multiplier state)
//   start      : load a (multiplicand) and b (multiplier) and begin
//   a, b       : operands, sampled only on start
//   done       : one-cycle completion pulse
//   product    : low WIDTH bits of a*b
//   hi_nz      : high WIDTH bits of a*b are nonzero
// -----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             hi_nz
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    // acc = {partial high half, remaining multiplier bits}; shifts right each step
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic [WIDTH:0]     sum_c;

    // Conditional add of the multiplicand into the high half, keeping the carry
    always_comb begin
        sum_c = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    end

    // Step sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc   <= {{WIDTH{1'b0}}, b};
                mcand <= a;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                acc <= {sum_c, acc[WIDTH-1:1]};
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc[WIDTH-1:0];
    assign hi_nz   = |acc[2*WIDTH-1:WIDTH];

endmodule : alu_mul_iter

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
// Valid/ready ALU. Single-cycle ops complete one edge after acceptance; MUL
// (only when ALU_MULTICYCLE_MUL_EN is defined) runs through the iterative
// multiplier and completes WIDTH+1 edges after acceptance. Result and flags
// are registered and held in DONE until out_ready.
//   Build macro: ALU_MULTICYCLE_MUL_EN -- defined: op 11 = unsigned multiply;
//                undefined: no multiplier, op 11 reported as illegal.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operation handshake (in_ready only in IDLE)
//   op, a, b            : opcode and operands (shifts: a = amount, b = value)
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   result              : WIDTH-bit result
//   sf, zf, of, cf, err : sign, zero, overflow, carry/borrow, illegal-op
// -----------------------------------------------------------------------------
module alu_multicycle
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             sf,
    output logic             zf,
    output logic             of,
    output logic             cf,
    output logic             err
);

    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("alu_multicycle: WIDTH must be a power of two >= 8");
    end

    alu_state_e state;

    // Single-cycle datapath results
    logic [WIDTH-1:0]   alu_res;
    logic               alu_of;
    logic               alu_cf;
    logic               alu_err;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     inc_w;
    logic [WIDTH:0]     dec_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [WIDTH:0]     sar_w;
    logic               amt_big;
    logic [SHAMT_W-1:0] sh;
    logic               accept;
    logic               mul_start;

    assign accept = (state == ST_IDLE) && in_valid;

`ifdef ALU_MULTICYCLE_MUL_EN
    logic             mul_done;
    logic             mul_hi_nz;
    logic [WIDTH-1:0] mul_lo;

    assign mul_start = accept && (op == OP_W'(OP_MUL));

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_lo),
        .hi_nz   (mul_hi_nz)
    );
`else
    assign mul_start = 1'b0;
`endif

    // Single-cycle ALU. Shift results are formed one bit wider so the last bit
    // shifted out lands in the extra bit (zero when the amount is zero).
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        inc_w   = {1'b0, a} + (WIDTH+1)'(1);
        dec_w   = {1'b0, a} - (WIDTH+1)'(1);
        amt_big = (a >= WIDTH'(WIDTH));
        sh      = a[SHAMT_W-1:0];
        shl_w   = {1'b0, b} << sh;
        shr_w   = {b, 1'b0} >> sh;
        sar_w   = (WIDTH+1)'($signed({b, 1'b0}) >>> sh);

        alu_res = '0;
        alu_of  = 1'b0;
        alu_cf  = 1'b0;
        alu_err = 1'b0;

        case (op)
            OP_W'(OP_ADD): begin
                alu_res = add_w[WIDTH-1:0];
                alu_cf  = add_w[WIDTH];
                alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_W'(OP_SUB): begin
                alu_res = sub_w[WIDTH-1:0];
                alu_cf  = sub_w[WIDTH];
                alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] == b[WIDTH-1]);
            end
            OP_W'(OP_AND): alu_res = a & b;
            OP_W'(OP_XOR): alu_res = a ^ b;
            OP_W'(OP_OR):  alu_res = a | b;
            OP_W'(OP_NOT): alu_res = ~a;
            OP_W'(OP_INC): begin
                alu_res = inc_w[WIDTH-1:0];
                alu_cf  = inc_w[WIDTH];
                alu_of  = (a == {1'b0, {(WIDTH-1){1'b1}}});
            end
            OP_W'(OP_DEC): begin
                alu_res = dec_w[WIDTH-1:0];
                alu_cf  = dec_w[WIDTH];
                alu_of  = (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_W'(OP_SHL): begin
                alu_res = amt_big ? '0 : shl_w[WIDTH-1:0];
                alu_cf  = amt_big ? 1'b0 : shl_w[WIDTH];
            end
            OP_W'(OP_SHR): begin
                alu_res = amt_big ? '0 : shr_w[WIDTH:1];
                alu_cf  = amt_big ? 1'b0 : shr_w[0];
            end
            OP_W'(OP_SAR): begin
                alu_res = amt_big ? {WIDTH{b[WIDTH-1]}} : sar_w[WIDTH:1];
                alu_cf  = amt_big ? 1'b0 : sar_w[0];
            end
`ifdef ALU_MULTICYCLE_MUL_EN
            // Completed through BUSY; nothing from the single-cycle path
            OP_W'(OP_MUL): alu_err = 1'b0;
`endif
            default:       alu_err = 1'b1;
        endcase
    end

    // Handshake FSM with registered result, flags and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            sf        <= 1'b0;
            zf        <= 1'b0;
            of        <= 1'b0;
            cf        <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        state    <= ST_BUSY;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        state     <= ST_DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= alu_res;
                        sf        <= alu_res[WIDTH-1];
                        zf        <= (alu_res == '0);
                        of        <= alu_of;
                        cf        <= alu_cf;
                        err       <= alu_err;
                    end
                end
`ifdef ALU_MULTICYCLE_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= mul_lo;
                        sf        <= mul_lo[WIDTH-1];
                        zf        <= (mul_lo == '0);
                        of        <= 1'b0;
                        cf        <= mul_hi_nz;
                        err       <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    // Release only; acceptance waits for the next IDLE cycle
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : alu_multicycle

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
// Table-driven vectors plus a reference model for random operations; expected
// results queue on issue and are popped when out_valid appears. Hand-written
// sequences cover DONE hold, reset in DONE and reset mid-multiply.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam int unsigned W = 32;

`ifdef ALU_MULTICYCLE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op        = 4'd0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         sf, zf, of, cf, err;
    logic [4:0]   dflags;

    assign dflags = {sf, zf, of, cf, err};

    alu_multicycle #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sf        (sf),
        .zf        (zf),
        .of        (of),
        .cf        (cf),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flags;   // {sf, zf, of, cf, err}
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } sb_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flags;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] r, input logic [4:0] f);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.flags = f;
        return v;
    endfunction

    // Reference model: overflow from exact signed arithmetic, shifts bit by bit
    function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        m;
        logic [31:0] r;
        logic        c, v, e;
        longint      sx, sy, s;
        logic [63:0] p;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd0: begin
                r = x + y; s = sx + sy;
                v = (s != longint'($signed(r)));
                p = {32'b0, x} + {32'b0, y};
                c = p[32];
            end
            4'd1: begin
                r = x - y; s = sx - sy;
                v = (s != longint'($signed(r)));
                c = (x < y);
            end
            4'd2: r = x & y;
            4'd3: r = x ^ y;
            4'd4: begin r = x + 32'd1; c = (x == 32'hFFFF_FFFF); v = (x == 32'h7FFF_FFFF); end
            4'd5: begin r = x - 32'd1; c = (x == 32'h0);         v = (x == 32'h8000_0000); end
            4'd6: r = ~x;
            4'd7: r = x | y;
            4'd8, 4'd9, 4'd10: begin
                if (x >= 32'd32) begin
                    r = (o == 4'd10) ? {32{y[31]}} : 32'h0;
                end else begin
                    r = y;
                    for (int i = 0; i < int'(x); i++) begin
                        if (o == 4'd8) begin c = r[31]; r = {r[30:0], 1'b0}; end
                        else           begin c = r[0];  r = {(o == 4'd10) ? r[31] : 1'b0, r[31:1]}; end
                    end
                end
            end
            4'd11: begin
                if (MUL_EN) begin
                    p = {32'b0, x} * {32'b0, y};
                    r = p[31:0];
                    c = (p[63:32] != 32'h0);
                end else begin
                    e = 1'b1;
                end
            end
            default: e = 1'b1;
        endcase
        m.res   = r;
        m.flags = {r[31], r == 32'h0, v, c, e};
        return m;
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
        return (MUL_EN && o == 4'd11) ? 33 : 1;
    endfunction

    // Issue one op from IDLE, wait for out_valid, compare; leaves the DUT in DONE
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eres, input logic [4:0] eflg, input bit junk,
                         output bit ok);
        sb_t   e;
        int    n;
        string nm;
        nm = $sformatf("op%0d_a%0h_b%0h", o, x, y);
        ok = 1'b0;
        n  = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk({nm, ".in_ready"}, 64'(in_ready), 64'(1));
        if (!in_ready) return;
        e.res = eres; e.flags = eflg; e.lat = exp_lat(o);
        sb_q.push_back(e);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        n = 1;
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
            end
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        chk({nm, ".out_valid"}, 64'(out_valid), 64'(1));
        if (!out_valid) return;
        chk({nm, ".latency"}, 64'(n), 64'(e.lat));
        chk({nm, ".result"},  64'(result), 64'(e.res));
        chk({nm, ".flags"},   64'(dflags), 64'(e.flags));
        chk({nm, ".busy_in_ready"}, 64'(in_ready), 64'(0));
        ok = 1'b1;
    endtask

    // Full transaction: issue then release with out_ready for one cycle
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eres, input logic [4:0] eflg, input bit junk);
        bit ok;
        issue(o, x, y, eres, eflg, junk, ok);
        if (!ok) return;
        out_ready = 1'b1;
        if (junk) in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk($sformatf("op%0d.release", o), 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    initial begin
        bit   ok;
        int   bad;
        res_t m;
        logic [3:0]  ro;
        logic [31:0] rx, ry;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'(0));
        chk("reset.result",    64'(result), 64'(0));
        chk("reset.flags",     64'(dflags), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.idle", 64'({in_ready, out_valid}), 64'(2'b10));

        // Directed vectors
        vecs.push_back(mk(4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 5'b10100));
        vecs.push_back(mk(4'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 5'b10010));
        vecs.push_back(mk(4'd1,  32'h5,         32'h5,         32'h0,         5'b01000));
        vecs.push_back(mk(4'd8,  32'h1,         32'h8000_0001, 32'h2,         5'b00010));
        vecs.push_back(mk(4'd10, 32'd40,        32'h8000_0000, 32'hFFFF_FFFF, 5'b10000));
        vecs.push_back(mk(4'd9,  32'h0,         32'h7,         32'h7,         5'b00000));
        vecs.push_back(mk(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b10000));
        vecs.push_back(mk(4'd3,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 5'b00000));
        vecs.push_back(mk(4'd7,  32'h0,         32'h0,         32'h0,         5'b01000));
        vecs.push_back(mk(4'd6,  32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 5'b10000));
        vecs.push_back(mk(4'd4,  32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 5'b10100));
        vecs.push_back(mk(4'd4,  32'hFFFF_FFFF, 32'h0,         32'h0,         5'b01010));
        vecs.push_back(mk(4'd5,  32'h8000_0000, 32'h0,         32'h7FFF_FFFF, 5'b00100));
        vecs.push_back(mk(4'd5,  32'h0,         32'h0,         32'hFFFF_FFFF, 5'b10010));
        vecs.push_back(mk(4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         5'b01010));
        vecs.push_back(mk(4'd0,  32'h8000_0000, 32'h8000_0000, 32'h0,         5'b01110));
        vecs.push_back(mk(4'd9,  32'd32,        32'hFFFF_FFFF, 32'h0,         5'b01000));
        vecs.push_back(mk(4'd9,  32'd4,         32'h18,        32'h1,         5'b00010));
        vecs.push_back(mk(4'd8,  32'd31,        32'h3,         32'h8000_0000, 5'b10010));
        vecs.push_back(mk(4'd10, 32'd4,         32'h8000_0010, 32'hF800_0001, 5'b10000));
        vecs.push_back(mk(4'd10, 32'd0,         32'h8000_0000, 32'h8000_0000, 5'b10000));
        vecs.push_back(mk(4'd8,  32'd32,        32'hFFFF_FFFF, 32'h0,         5'b01000));
        vecs.push_back(mk(4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 5'b00100));
        vecs.push_back(mk(4'd12, 32'h5,         32'h6,         32'h0,         5'b01001));
        vecs.push_back(mk(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         5'b01001));
        if (MUL_EN) begin
            vecs.push_back(mk(4'd11, 32'h1_0000, 32'h1_0000, 32'h0, 5'b01010));
            vecs.push_back(mk(4'd11, 32'h3,      32'h5,      32'hF, 5'b00000));
        end else begin
            vecs.push_back(mk(4'd11, 32'h1_0000, 32'h1_0000, 32'h0, 5'b01001));
            vecs.push_back(mk(4'd11, 32'h3,      32'h5,      32'h0, 5'b01001));
        end
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, 1'b0);
        end

        // Random ops against the model, with junk inputs while busy / done
        for (int i = 0; i < 30; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = $urandom;
            if (ro >= 4'd8 && ro <= 4'd10) rx = 32'($urandom_range(0, 40));
            m = model(ro, rx, ry);
            run_op(ro, rx, ry, m.res, m.flags, 1'b1);
        end

        // Hold in DONE for 10 cycles while inputs toggle
        issue(4'd0, 32'd2, 32'd3, 32'd5, 5'b00000, 1'b0, ok);
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
            @(negedge clk);
            chk($sformatf("hold.c%0d", i), 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, 32'd5}));
        end
        out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("hold.release", 64'({in_ready, out_valid}), 64'(2'b10));
        @(negedge clk);
        chk("hold.no_accept", 64'({in_ready, out_valid, result}), 64'({1'b1, 1'b0, 32'd5}));

        // Reset while in DONE
        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b10100, 1'b0, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done.now", 64'({out_valid, result, dflags}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin @(negedge clk); if (out_valid) bad++; end
        chk("rst_done.stale", 64'(bad), 64'(0));
        run_op(4'd0, 32'd2, 32'd3, 32'd5, 5'b00000, 1'b0);

        // Reset mid-multiply (cycle 10 after accept)
        if (MUL_EN) begin
            in_valid = 1'b1; op = 4'd11; a = 32'h1_0000; b = 32'h1_0000;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_mul.now", 64'({out_valid, result, dflags}), 64'(0));
            @(negedge clk);
            rst_n = 1'b1;
            bad = 0;
            repeat (40) begin @(negedge clk); if (out_valid) bad++; end
            chk("rst_mul.stale", 64'(bad), 64'(0));
            run_op(4'd0, 32'd2, 32'd3, 32'd5, 5'b00000, 1'b0);
        end

        chk("scoreboard.empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule : tb_alu_multicycle
